// File: rtl/ni_flit_injector.sv
// NI transmit side: splits core packets into hdr/body/tail flits toward a router input port,
// spending per-VC credits. Optional stats counters under NI_FLIT_INJECTOR_STATS_EN.
module ni_flit_injector #(
   parameter int V    = 4,
   parameter int B    = 4,
   parameter int Fpay = 32,
   parameter int LENw = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pck_valid,
   output logic            pck_ready,
   input  logic [LENw-1:0] pck_len,
   input  logic [Fpay-1:0] pck_hdr,
   input  logic            data_valid,
   output logic            data_ready,
   input  logic [Fpay-1:0] data_in,
   output logic            flit_wr,
   output logic            flit_hdr,
   output logic            flit_tail,
   output logic [V-1:0]    flit_vc,
   output logic [Fpay-1:0] flit_payload,
   input  logic [V-1:0]    credit_in,
   output logic            busy
`ifdef NI_FLIT_INJECTOR_STATS_EN
   ,
   output logic [31:0]     sent_flit_cnt,
   output logic [31:0]     sent_pck_cnt
`endif
);

   localparam int CW = $clog2(B + 1);
   localparam int VW = (V > 1) ? $clog2(V) : 1;

   typedef enum logic [1:0] {IDLE, ALLOC, BODY} state_t;

   typedef struct packed {
      logic            hdr;
      logic            tail;
      logic [V-1:0]    vc;
      logic [Fpay-1:0] payload;
   } flit_t;

   state_t                  state, state_n;
   flit_t                   flit_q, iss;
   logic                    issue, accept, alloc_go;
   logic [LENw-1:0]         len_q, rem, eff_len;
   logic [Fpay-1:0]         hdr_q;
   logic [VW-1:0]           vc_q, rr_ptr, pick_idx;
   logic [VW:0]             pick;
   logic [V-1:0]            credit_ok;
   logic [V-1:0][CW-1:0]    cnt;

   function automatic logic [V-1:0] onehot(input logic [VW-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

   // Scan from the highest offset down so the lowest offset from ptr is the last writer.
   function automatic logic [VW:0] rr_pick(input logic [V-1:0] ok, input logic [VW-1:0] ptr);
      int j;
      rr_pick = '0;
      for (int i = V - 1; i >= 0; i--) begin
         j = (int'(ptr) + i) % V;
         if (ok[j]) rr_pick = {1'b1, VW'(j)};
      end
   endfunction

   // Per-VC credit counters. A flit on the wire this cycle already owns a slot, so it is
   // excluded from the availability test before its decrement lands.
   for (genvar v = 0; v < V; v++) begin : g_vc
      logic dec, inc;
      assign dec = flit_wr & flit_vc[v];
      assign inc = credit_in[v];
      assign credit_ok[v] = dec ? (cnt[v] > CW'(1)) : (cnt[v] != '0);

      always_ff @(posedge clk) begin
         if (reset) begin
            cnt[v] <= CW'(B);
         end else begin
            assert (!(inc && !dec && cnt[v] == CW'(B)));
            assert (!(dec && !inc && cnt[v] == '0));
            if (inc && !dec)      cnt[v] <= cnt[v] + CW'(1);
            else if (dec && !inc) cnt[v] <= cnt[v] - CW'(1);
         end
      end
   end

   assign pick     = rr_pick(credit_ok, rr_ptr);
   assign pick_idx = pick[VW-1:0];
   assign eff_len  = (pck_len == '0) ? LENw'(1) : pck_len;

   always_comb begin
      state_n    = state;
      pck_ready  = 1'b0;
      data_ready = 1'b0;
      issue      = 1'b0;
      accept     = 1'b0;
      alloc_go   = 1'b0;
      iss        = '0;
      case (state)
         IDLE: begin
            pck_ready = !reset;
            if (pck_valid && !reset) begin
               accept  = 1'b1;
               state_n = ALLOC;
            end
         end
         ALLOC: begin
            if (pick[VW]) begin
               alloc_go    = 1'b1;
               issue       = 1'b1;
               iss.hdr     = 1'b1;
               iss.tail    = (len_q == LENw'(1));
               iss.vc      = onehot(pick_idx);
               iss.payload = hdr_q;
               state_n     = (len_q == LENw'(1)) ? IDLE : BODY;
            end
         end
         BODY: begin
            data_ready = credit_ok[vc_q] && !reset;
            if (data_valid && data_ready) begin
               issue       = 1'b1;
               iss.tail    = (rem == LENw'(1));
               iss.vc      = onehot(vc_q);
               iss.payload = data_in;
               if (rem == LENw'(1)) state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         flit_wr <= 1'b0;
         flit_q  <= '0;
         len_q   <= '0;
         hdr_q   <= '0;
         rem     <= '0;
         vc_q    <= '0;
         rr_ptr  <= '0;
      end else begin
         state   <= state_n;
         flit_wr <= issue;
         if (issue) flit_q <= iss;
         if (accept) begin
            len_q <= eff_len;
            hdr_q <= pck_hdr;
            rem   <= eff_len - LENw'(1);
         end
         if (alloc_go) begin
            vc_q   <= pick_idx;
            rr_ptr <= (pick_idx == VW'(V - 1)) ? '0 : pick_idx + VW'(1);
         end
         if (issue && state == BODY) rem <= rem - LENw'(1);
      end
   end

   assign flit_hdr     = flit_q.hdr;
   assign flit_tail    = flit_q.tail;
   assign flit_vc      = flit_q.vc;
   assign flit_payload = flit_q.payload;
   assign busy         = (state != IDLE);

`ifdef NI_FLIT_INJECTOR_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         sent_flit_cnt <= '0;
         sent_pck_cnt  <= '0;
      end else if (flit_wr) begin
         sent_flit_cnt <= sent_flit_cnt + 32'd1;
         if (flit_tail) sent_pck_cnt <= sent_pck_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ni_flit_injector.sv
// Directed bench for ni_flit_injector: expected flits are queued when a packet is requested
// and checked in order as flit_wr pulses appear.
module tb_ni_flit_injector;
   localparam int V  = 4;
   localparam int FP = 32;
   localparam int LW = 8;
   localparam logic [31:0] WBASE = 32'hDA7A_0000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          pck_valid = 1'b0;
   logic          pck_ready;
   logic [LW-1:0] pck_len = '0;
   logic [FP-1:0] pck_hdr = '0;
   logic          data_valid = 1'b1;
   logic          data_ready;
   logic [FP-1:0] data_in;
   logic          flit_wr, flit_hdr, flit_tail, busy;
   logic [V-1:0]  flit_vc;
   logic [FP-1:0] flit_payload;
   logic [V-1:0]  credit_in;
   logic [V-1:0]  credit_man = '0;
   logic          auto_credit = 1'b0;

   int            dcnt = 0;
   int            checks = 0;
   int            errors = 0;
   logic [37:0]   exp_q[$];

   ni_flit_injector #(.V(V), .B(4), .Fpay(FP), .LENw(LW)) dut (
      .clk(clk), .reset(reset),
      .pck_valid(pck_valid), .pck_ready(pck_ready), .pck_len(pck_len), .pck_hdr(pck_hdr),
      .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
      .flit_wr(flit_wr), .flit_hdr(flit_hdr), .flit_tail(flit_tail), .flit_vc(flit_vc),
      .flit_payload(flit_payload), .credit_in(credit_in), .busy(busy)
   );

   always #5 clk = ~clk;

   // auto_credit returns each slot in the same cycle the flit is on the wire
   assign credit_in = credit_man | ({V{auto_credit & flit_wr}} & flit_vc);
   assign data_in   = WBASE + 32'(dcnt);

   always @(posedge clk) if (data_valid && data_ready) dcnt <= dcnt + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && flit_wr) begin
         if (exp_q.size() == 0) chk("unexpected_flit", 64'(1), 64'(0));
         else chk("flit", 64'({flit_hdr, flit_tail, flit_vc, flit_payload}), 64'(exp_q.pop_front()));
      end
   end

   task automatic send_pck(input logic [LW-1:0] len, input logic [31:0] hdr, input logic [3:0] vc);
      int n = 0;
      int L;
      L = (len == 0) ? 1 : int'(len);
      @(negedge clk);
      while (!pck_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("pck_ready_wait", 64'(pck_ready), 64'(1));
      pck_valid = 1'b1;
      pck_len   = len;
      pck_hdr   = hdr;
      exp_q.push_back({1'b1, L == 1, vc, hdr});
      for (int k = 1; k < L; k++) exp_q.push_back({1'b0, k == L - 1, vc, WBASE + 32'(dcnt + k - 1)});
      @(posedge clk);
      #1 pck_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int max);
      int n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy) && n < max) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'({exp_q.size(), busy}), 64'(0));
   endtask

   task automatic pulse_credit(input logic [3:0] m);
      @(posedge clk);
      #1 credit_man = m;
      @(posedge clk);
      #1 credit_man = '0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 exp_q.delete();
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_flit_wr", 64'(flit_wr), 64'(0));
      chk("rst_flit_vc", 64'(flit_vc), 64'(0));
      chk("rst_payload", 64'(flit_payload), 64'(0));
      chk("rst_pck_ready", 64'(pck_ready), 64'(0));
      chk("rst_data_ready", 64'(data_ready), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("idle_pck_ready", 64'(pck_ready), 64'(1));

      // single-flit packet: header 2 cycles after accept
      send_pck(8'd1, 32'hA000_0001, 4'b0001);
      @(negedge clk);
      chk("t1_lat_alloc", 64'(flit_wr), 64'(0));
      @(negedge clk);
      chk("t1_lat_hdr", 64'(flit_wr), 64'(1));
      wait_drain("t1_drain", 10);
      send_pck(8'd0, 32'hA000_0000, 4'b0010);
      wait_drain("t1_len0_drain", 10);

      // len=5 with no credit return stalls before the tail
      do_reset();
      send_pck(8'd5, 32'hB000_0005, 4'b0001);
      repeat (8) @(negedge clk);
      chk("t2_stall_q", 64'(exp_q.size()), 64'(1));
      chk("t2_stall_dready", 64'(data_ready), 64'(0));
      chk("t2_stall_busy", 64'(busy), 64'(1));
      pulse_credit(4'b0001);
      wait_drain("t2_tail_drain", 6);

      // round-robin over VCs with wrap
      do_reset();
      send_pck(8'd1, 32'hC000_0000, 4'b0001);
      send_pck(8'd1, 32'hC000_0001, 4'b0010);
      send_pck(8'd1, 32'hC000_0002, 4'b0100);
      send_pck(8'd1, 32'hC000_0003, 4'b1000);
      send_pck(8'd1, 32'hC000_0004, 4'b0001);
      wait_drain("t3_drain", 10);

      // exhaust every VC, then a single credit decides the header VC
      do_reset();
      send_pck(8'd4, 32'hD000_0000, 4'b0001);
      wait_drain("t4_ex0", 12);
      send_pck(8'd4, 32'hD000_0001, 4'b0010);
      wait_drain("t4_ex1", 12);
      send_pck(8'd4, 32'hD000_0002, 4'b0100);
      wait_drain("t4_ex2", 12);
      send_pck(8'd4, 32'hD000_0003, 4'b1000);
      wait_drain("t4_ex3", 12);
      send_pck(8'd1, 32'hD000_0010, 4'b0100);
      repeat (6) @(negedge clk);
      chk("t4_alloc_stall_q", 64'(exp_q.size()), 64'(1));
      chk("t4_alloc_busy", 64'(busy), 64'(1));
      pulse_credit(4'b0100);
      wait_drain("t4_vc2_drain", 6);
      pulse_credit(4'b1011);
      send_pck(8'd1, 32'hD000_0011, 4'b1000);
      wait_drain("t4_ptr_vc3", 8);

      // credit return coinciding with flit_wr leaves the counter unchanged
      do_reset();
      auto_credit = 1'b1;
      send_pck(8'd10, 32'hE000_000A, 4'b0001);
      wait_drain("t5_stream", 14);
      @(negedge clk);
      auto_credit = 1'b0;
      send_pck(8'd1, 32'hE000_0001, 4'b0010);
      send_pck(8'd1, 32'hE000_0002, 4'b0100);
      send_pck(8'd1, 32'hE000_0003, 4'b1000);
      wait_drain("t5_fill", 8);
      send_pck(8'd5, 32'hE000_0005, 4'b0001);
      repeat (8) @(negedge clk);
      chk("t5_vc0_full_q", 64'(exp_q.size()), 64'(1));

      // reset in the middle of a streaming body
      do_reset();
      auto_credit = 1'b1;
      send_pck(8'd20, 32'hF000_0014, 4'b0001);
      repeat (6) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 exp_q.delete();
      @(negedge clk);
      chk("t6_flit_wr", 64'(flit_wr), 64'(0));
      chk("t6_busy", 64'(busy), 64'(0));
      chk("t6_pck_ready", 64'(pck_ready), 64'(0));
      @(posedge clk);
      #1 reset = 1'b0;
      auto_credit = 1'b0;
      send_pck(8'd5, 32'hF000_0005, 4'b0001);
      repeat (8) @(negedge clk);
      chk("t6_counters_b_q", 64'(exp_q.size()), 64'(1));

      do_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
